// File: rtl/sdpb_line_reader_if.sv
// rtl/sdpb_line_reader_if.sv - buffer read port and pixel stream bundle for sdpb_line_reader
//
// Signals:
//   mem_adb   buffer word read address        (reader -> buffer)
//   mem_ceb   buffer read enable, one word/cy  (reader -> buffer)
//   mem_oce   buffer output-register enable    (reader -> buffer)
//   mem_dout  buffer read data, 2-cycle latency (buffer -> reader)
//   pix_data  RGB565 pixel                     (reader -> sink)
//   pix_valid pixel valid                      (reader -> sink)
//   pix_last  final pixel of the run           (reader -> sink)
//   pix_ready sink accepts pixel               (sink -> reader)
// Modports: master = the reader, slave = buffer plus pixel sink.

interface sdpb_line_reader_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] mem_adb;
    logic              mem_ceb;
    logic              mem_oce;
    logic [31:0]       mem_dout;
    logic [15:0]       pix_data;
    logic              pix_valid;
    logic              pix_last;
    logic              pix_ready;

    modport master (
        output mem_adb, mem_ceb, mem_oce,
        input  mem_dout,
        output pix_data, pix_valid, pix_last,
        input  pix_ready
    );

    modport slave (
        input  mem_adb, mem_ceb, mem_oce,
        output mem_dout,
        input  pix_data, pix_valid, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/sdpb_line_reader.sv
// rtl/sdpb_line_reader.sv - drains a run of 32-bit line-buffer words as a 16-bit RGB565 pixel stream
//
// Fetches word_count words starting at base_addr from the simple dual-port
// line buffer (2-cycle read latency), queues them in a small word FIFO and
// emits two pixels per word with valid/ready backpressure.
//
// Parameters:
//   ADDR_W      buffer word-address width (depth 2^ADDR_W)
//   FIFO_DEPTH  word FIFO entries, power of two, >= 3 for full throughput
// Ports:
//   clk, reset_n          clock (also the buffer's clkb), async active-low reset
//   start                 one-cycle run request, ignored while busy
//   base_addr, word_count run descriptor, sampled when start is accepted
//   busy                  run in progress, up to and including the done cycle
//   done                  one-cycle pulse after the last pixel handshake
//   bus                   sdpb_line_reader_if master: buffer read port + pixel stream
// Build option:
//   SDPB_LINE_READER_HI_FIRST_EN  emit the high half of each word first

module sdpb_line_reader #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    sdpb_line_reader_if.master  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;

    // Read pipeline: stage 1 = request issued last cycle, stage 2 = data on mem_dout now.
    logic                s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic                s2_v_q, s2_v_d, s2_last_q, s2_last_d;

    // Word FIFO; bit 32 tags the final word of the run.
    logic [32:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Unpacker half select: 0 = first half of the head word, 1 = second half.
    logic                half_q, half_d;

    logic [CNT_W:0]      credit_used;
    logic                issue;
    logic                push;
    logic                pop;
    logic                hs;
    logic                head_valid;
    logic [32:0]         head_word;
    logic [15:0]         first_half;
    logic [15:0]         second_half;

    // Words already in the FIFO plus words still in the read pipeline must
    // never exceed the FIFO size, so an issued read always has a slot waiting.
    assign credit_used = {1'b0, count_q} + (CNT_W+1)'(s1_v_q) + (CNT_W+1)'(s2_v_q);
    assign issue       = (state_q == FETCH) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign push        = s2_v_q;

    assign head_valid  = (count_q != '0);
    assign head_word   = fifo_mem_q[rd_ptr_q];
    assign hs          = head_valid && bus.pix_ready;
    // The head word leaves the FIFO as its second half is accepted, so the
    // next word is presented in the following cycle without a bubble.
    assign pop         = hs && half_q;

`ifdef SDPB_LINE_READER_HI_FIRST_EN
    assign first_half  = head_word[31:16];
    assign second_half = head_word[15:0];
`else
    assign first_half  = head_word[15:0];
    assign second_half = head_word[31:16];
`endif

    assign bus.mem_adb   = addr_q;
    assign bus.mem_ceb   = issue;
    assign bus.mem_oce   = 1'b1;
    // Data is forced to zero when idle so stale FIFO contents never show.
    assign bus.pix_valid = head_valid;
    assign bus.pix_data  = head_valid ? (half_q ? second_half : first_half) : 16'h0000;
    assign bus.pix_last  = head_valid && half_q && head_word[32];

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        addr_d   = addr_q;
        remain_d = remain_q;

        if (issue) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - (ADDR_W+1)'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d   = 1'b1;
                    addr_d   = base_addr;
                    remain_d = word_count;
                    state_d  = (word_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue && (remain_q == (ADDR_W+1)'(1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Leave on the handshake that empties the last word, so done
                // lands in the very next cycle.
                if (!s1_v_q && !s2_v_q &&
                    ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                // A zero-length run arrives here without done set; it pulses
                // done one cycle later so the pulse always leaves DONE.
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_v_d    = issue;
        s1_last_d = issue && (remain_q == (ADDR_W+1)'(1));
        s2_v_d    = s1_v_q;
        s2_last_d = s1_last_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        half_d    = hs ? ~half_q : half_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            half_q    <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            s2_v_q    <= s2_v_d;
            s2_last_q <= s2_last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            half_q    <= half_d;
        end
    end

    // Storage only; validity comes from count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {s2_last_q, bus.mem_dout};
        end
    end

endmodule

// File: doc/sdpb_line_reader.md
# sdpb_line_reader

Read-side controller for the 1K×32 simple dual-port line buffer. On a start command it fetches a run of 32-bit words from the buffer's read port and unpacks each word into two 16-bit RGB565 pixels on a valid/ready stream, with full backpressure support. The camera capture path writes the buffer; this block drains it toward the display/PSRAM side.

## Interface
- `ADDR_W`, 10: buffer word-address width. The buffer depth is 2^ADDR_W words.
- `FIFO_DEPTH`, 4: word-FIFO entries. Must be a power of two and ≥ 3 to reach full throughput.
- `clk` in 1: the single clock. It drives the buffer's `clkb`.
- `reset_n` in 1: reset, asynchronous, active-low. It clears all state.
- `start` in 1: one-cycle request. It is ignored while `busy`=1.
- `base_addr` in ADDR_W: first word address. Sampled when `start` is accepted.
- `word_count` in ADDR_W+1: number of words to read, range 0..2^ADDR_W. Sampled when `start` is accepted.
- `busy` out 1: high from the cycle after `start` is accepted until the `done` cycle.
- `done` out 1: one-cycle pulse after the last pixel handshake.
- `mem_adb` out ADDR_W: buffer read address.
- `mem_ceb` out 1: buffer read enable. One word is requested per cycle in which it is high.
- `mem_oce` out 1: buffer output-register enable. Tied high.
- `mem_dout` in 32: buffer read data.
- `pix_data` out 16: pixel.
- `pix_valid` out 1: pixel valid.
- `pix_ready` in 1: downstream accept.
- `pix_last` out 1: marks the final pixel of the run. Qualified by `pix_valid`.

## Operation
- FSM states: IDLE, FETCH, FLUSH, DONE.
- IDLE: `start` with `word_count`>0 loads the address counter and remaining count, then moves to FETCH.
- IDLE, zero count: `start` with `word_count`=0 moves straight to DONE. No reads are issued and no pixels are produced.
- FETCH: `mem_ceb`=1 with `mem_adb`=current address in every cycle where (FIFO occupancy + reads in flight) < FIFO_DEPTH.
- After each issued read, the address increments modulo 2^ADDR_W (wrap 1023→0 for ADDR_W=10) and the remaining count decrements. When the count reaches 0 the FSM moves to FLUSH.
- FLUSH: no reads are issued. The FSM waits until the in-flight count is 0, the FIFO is empty, and the unpacker is empty, then moves to DONE.
- DONE: `done`=1 for one cycle, then the FSM returns to IDLE. `start` is accepted again in the IDLE cycle that follows DONE, not in the DONE cycle itself.
- In-flight tracking: a 2-stage valid shift register mirrors the buffer's pipelined read latency. Stage 2 writes `mem_dout` into the word FIFO.
- Unpacker: pops one FIFO word and presents the two halves in order, low half first (`[15:0]`) then high half (`[31:16]`).
- A new word is popped in the same cycle the second half is accepted, so there are no bubbles while the FIFO is non-empty.
- `pix_last`=1 on the high half of the final word.
- Stream rules: `pix_data`/`pix_last` hold stable while `pix_valid`=1 and `pix_ready`=0. `pix_valid` never drops without a handshake.
- Credit rule: the issue gate guarantees the FIFO can never overflow. There is no overflow path.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_ceb`=0, `mem_adb`=0, `pix_valid`=0, `pix_data`=0, `pix_last`=0, `mem_oce`=1. The FSM resets to IDLE; the FIFO and in-flight counters reset to 0.
- Read latency: a request issued in cycle t returns data on `mem_dout` in cycle t+2, which is written into the FIFO at the end of t+2.
- Start to first pixel: `start` in cycle 0, first read in cycle 1, first `pix_valid`=1 in cycle 4.
- Throughput: with `pix_ready` held at 1, one pixel per cycle sustained, i.e. one read every 2 cycles.
- `done` asserts the cycle after the last pixel handshake.
- Reset mid-run: everything is cleared immediately (asynchronous). No `done` pulse. Stale buffer data arriving after reset is discarded.
- A `start` that coincides with `done`, or arrives while busy, is dropped.

## Configuration
- `SDPB_LINE_READER_HI_FIRST_EN`
  - Defined: each word is emitted high half (`[31:16]`) first, then low half. `pix_last` moves to the low half of the final word.
  - Undefined (default): low half first, as described above.

## Test plan
- Basic run, with `pix_ready`=1, buffer word n = {16'hB000+n, 16'hA000+n}:
  - Stimulus: `base_addr`=5, `word_count`=3.
  - Required pixels: A005, B005, A006, B006, A007, B007 on consecutive cycles starting at cycle 4.
  - `pix_last` only on B007; `done` one cycle later.
- Wrap-around:
  - Stimulus: `base_addr`=1022, `word_count`=4.
  - Required: reads at 1022, 1023, 0, 1 in that order, giving 8 pixels.
- Backpressure:
  - Stimulus: `word_count`=16, `pix_ready` toggled in a random pattern.
  - Required: no pixels lost or duplicated, data stable while stalled, FIFO never exceeds 4.
  - With `pix_ready`=0 held for 20 cycles: at most 4 reads issued.
- Zero length:
  - Stimulus: `start` with `word_count`=0.
  - Required: `done` 2 cycles later, `pix_valid` never asserted, `mem_ceb` never asserted.
- Reset mid-run:
  - Stimulus: deassert `reset_n` after the 5th pixel of a 32-word run.
  - Required: all outputs at reset values in the same cycle, then a fresh 2-word run produces correct data.
- Macro build:
  - Stimulus: `SDPB_LINE_READER_HI_FIRST_EN` defined, basic run.
  - Required order: B005, A005, B006, A006, B007, A007, with `pix_last` on A007.
